// File: rtl/control_unit.sv
// Multi-cycle control unit: FETCH/LOAD/EXEC sequencing, instruction decode,
// 10-bit program counter and a zero-flag register used by conditional jumps.
module control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        zero,
  output logic [9:0]  pc,
  output logic [2:0]  op_alu,
  output logic [3:0]  ra1,
  output logic [3:0]  ra2,
  output logic [3:0]  wa,
  output logic        we3,
  output logic        s_inm,
  output logic [7:0]  inm,
  output logic        halted,
  output logic [1:0]  o_dbg_state,
  output logic        o_dbg_zf
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_LOAD  = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [9:0]  r_pc;
  logic [9:0]  w_next_pc;
  logic [9:0]  w_pc_inc;
  logic [15:0] r_ir;
  logic        r_zf;
  logic        w_is_alu;
  logic        w_is_loadi;

  assign w_is_alu   = r_ir[15];
  assign w_is_loadi = (r_ir[15:12] == 4'b0000);
  assign w_pc_inc   = r_pc + 10'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_pc    <= 10'd0;
      r_ir    <= 16'h4000;
      r_zf    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      if (r_state == S_LOAD)
        r_ir <= instr;
      if ((r_state == S_EXEC) && w_is_alu)
        r_zf <= zero;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    case (r_state)
      S_FETCH: w_next_state = S_LOAD;
      S_LOAD:  w_next_state = S_EXEC;
      S_EXEC: begin
        w_next_state = S_FETCH;
        w_next_pc    = w_pc_inc;
        if (!w_is_alu) begin
          case (r_ir[14:12])
            3'b001: w_next_pc = r_ir[9:0];
            3'b010: w_next_pc = r_zf ? r_ir[9:0] : w_pc_inc;
            3'b011: w_next_pc = r_zf ? w_pc_inc : r_ir[9:0];
            3'b101: begin
              w_next_state = S_HALT;
              w_next_pc    = r_pc;
            end
            default: w_next_pc = w_pc_inc;
          endcase
        end
      end
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_FETCH;
    endcase
  end

  // Write enable is qualified by reset so a reset landing on EXEC suppresses the write.
  assign we3         = (r_state == S_EXEC) && (w_is_alu || w_is_loadi) && reset;
  assign pc          = r_pc;
  assign op_alu      = w_is_alu ? r_ir[14:12] : 3'b000;
  assign ra1         = r_ir[11:8];
  assign ra2         = r_ir[7:4];
  assign wa          = r_ir[3:0];
  assign inm         = r_ir[11:4];
  assign s_inm       = w_is_loadi;
  assign halted      = (r_state == S_HALT);
  assign o_dbg_state = r_state;
  assign o_dbg_zf    = r_zf;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: drives instructions straight onto instr
// in step with the FETCH/LOAD/EXEC sequence and checks hand-computed results.
module tb_control_unit;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  logic        clk;
  logic        reset;
  logic [15:0] instr;
  logic        zero;
  logic [9:0]  pc;
  logic [2:0]  op_alu;
  logic [3:0]  ra1, ra2, wa;
  logic        we3, s_inm, halted;
  logic [7:0]  inm;
  logic [1:0]  dbg_state;
  logic        dbg_zf;

  int n_checks = 0;
  int n_fail   = 0;

  control_unit dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .zero        (zero),
    .pc          (pc),
    .op_alu      (op_alu),
    .ra1         (ra1),
    .ra2         (ra2),
    .wa          (wa),
    .we3         (we3),
    .s_inm       (s_inm),
    .inm         (inm),
    .halted      (halted),
    .o_dbg_state (dbg_state),
    .o_dbg_zf    (dbg_zf)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in FETCH, presents ins, ends positioned inside EXEC with zero=z.
  task automatic to_exec(input logic [15:0] ins, input logic z);
    check("fetch_state", 16'(dbg_state), 16'(ST_FETCH));
    check("fetch_we3", 16'(we3), 16'h0);
    instr = ins;
    step();
    check("load_state", 16'(dbg_state), 16'(ST_LOAD));
    check("load_we3", 16'(we3), 16'h0);
    step();
    zero = z;
    check("exec_state", 16'(dbg_state), 16'(ST_EXEC));
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic z,
                           input logic exp_we3, input logic [9:0] exp_pc);
    to_exec(ins, z);
    check("exec_we3", 16'(we3), 16'(exp_we3));
    step();
    check("next_pc", 16'(pc), 16'(exp_pc));
  endtask

  initial begin
    reset = 1'b0;
    instr = 16'h0000;
    zero  = 1'b0;

    // reset held for two cycles
    step();
    step();
    check("rst_pc", 16'(pc), 16'h0);
    check("rst_we3", 16'(we3), 16'h0);
    check("rst_halted", 16'(halted), 16'h0);
    check("rst_op_alu", 16'(op_alu), 16'h0);
    check("rst_s_inm", 16'(s_inm), 16'h0);
    check("rst_zf", 16'(dbg_zf), 16'h0);
    reset = 1'b1;
    check("first_fetch", 16'(dbg_state), 16'(ST_FETCH));

    // LOADI 0x0A53: inm=A5, wa=3
    to_exec(16'h0A53, 1'b0);
    check("loadi_we3", 16'(we3), 16'h1);
    check("loadi_inm", 16'(inm), 16'h00A5);
    check("loadi_wa", 16'(wa), 16'h3);
    check("loadi_s_inm", 16'(s_inm), 16'h1);
    check("loadi_op_alu", 16'(op_alu), 16'h0);
    check("loadi_pc_hold", 16'(pc), 16'h0);
    step();
    check("loadi_pc", 16'(pc), 16'h1);
    check("loadi_we3_drop", 16'(we3), 16'h0);

    // SUB r5 = r1 - r2 with zero=1, then JZ taken
    to_exec(16'hB125, 1'b1);
    check("sub_we3", 16'(we3), 16'h1);
    check("sub_op_alu", 16'(op_alu), 16'h3);
    check("sub_ra1", 16'(ra1), 16'h1);
    check("sub_ra2", 16'(ra2), 16'h2);
    check("sub_wa", 16'(wa), 16'h5);
    check("sub_s_inm", 16'(s_inm), 16'h0);
    step();
    check("sub_zf", 16'(dbg_zf), 16'h1);
    check("sub_pc", 16'(pc), 16'h2);
    run_instr(16'h2155, 1'b0, 1'b0, 10'h155);
    check("jz_op_alu_seen", 16'(op_alu), 16'h0);

    // zero=0: JZ falls through, JNZ jumps
    run_instr(16'hB125, 1'b0, 1'b1, 10'h156);
    check("sub0_zf", 16'(dbg_zf), 16'h0);
    run_instr(16'h2155, 1'b1, 1'b0, 10'h157);
    run_instr(16'h3155, 1'b1, 1'b0, 10'h155);

    // zf survives LOADI; JNZ with zf=1 falls through
    run_instr(16'hB125, 1'b1, 1'b1, 10'h156);
    run_instr(16'h0000, 1'b0, 1'b1, 10'h157);
    check("loadi_keeps_zf", 16'(dbg_zf), 16'h1);
    run_instr(16'h3155, 1'b0, 1'b0, 10'h158);
    run_instr(16'h4000, 1'b0, 1'b0, 10'h159);

    // JMP to 1023, NOP wraps to 0
    run_instr(16'h13FF, 1'b0, 1'b0, 10'h3FF);
    run_instr(16'h7123, 1'b0, 1'b0, 10'h000);
    run_instr(16'h4000, 1'b0, 1'b0, 10'h001);

    // HALT at pc=1
    run_instr(16'h5000, 1'b0, 1'b0, 10'h001);
    instr = 16'h0A53;
    for (int i = 0; i < 20; i++) begin
      check("halt_halted", 16'(halted), 16'h1);
      check("halt_pc", 16'(pc), 16'h1);
      check("halt_we3", 16'(we3), 16'h0);
      step();
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("halt_rst_pc", 16'(pc), 16'h0);
    check("halt_rst_halted", 16'(halted), 16'h0);
    check("halt_rst_state", 16'(dbg_state), 16'(ST_FETCH));

    // reset during EXEC of an ALU op
    run_instr(16'hB125, 1'b1, 1'b1, 10'h001);
    to_exec(16'hB125, 1'b1);
    reset = 1'b0;
    #1;
    check("midexec_we3", 16'(we3), 16'h0);
    step();
    reset = 1'b1;
    check("midexec_pc", 16'(pc), 16'h0);
    check("midexec_zf", 16'(dbg_zf), 16'h0);
    check("midexec_state", 16'(dbg_state), 16'(ST_FETCH));
    check("midexec_we3_after", 16'(we3), 16'h0);

    // normal restart after that reset
    run_instr(16'h0A53, 1'b0, 1'b1, 10'h001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle control unit for the 8-bit datapath: fetches 16-bit instructions from a synchronous-read instruction memory, decodes them, drives the 3-bit ALU operation code and register-file controls, and samples the ALU zero flag to resolve conditional jumps. It is the producer of `op_alu` and the consumer of `zero`. It owns the 10-bit program counter.

## Interface
- No parameters. PC width is fixed at 10 bits, the instruction at 16 bits, and the register file at 16×8.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-low. Sampled on the `clk` edge; 0 means reset.
- `instr` input 16: instruction memory data. Valid one cycle after `pc` is presented (registered read).
- `zero` input 1: ALU zero flag, combinational from the ALU result.
- `pc` output 10: instruction memory address.
- `op_alu` output 3: ALU operation code.
- `ra1`, `ra2` output 4 each: register-file read addresses.
- `wa` output 4: register-file write address.
- `we3` output 1: register-file write enable.
- `s_inm` output 1: write-data select. 1 selects `inm`, 0 selects the ALU result.
- `inm` output 8: immediate value.
- `halted` output 1: high while in HALT.

## Operation
- Instruction decode uses `ir`, the internal instruction register.
- `ir[15]=1` is an ALU op:
  - `op_alu=ir[14:12]`, `ra1=ir[11:8]`, `ra2=ir[7:4]`, `wa=ir[3:0]`, `s_inm=0`.
  - Writes the ALU result to `wa`.
  - Updates the zero flag register `zf` with `zero`.
- `ir[15:12]=0000` is LOADI: `inm=ir[11:4]`, `wa=ir[3:0]`, `s_inm=1`. Writes `inm`; `zf` is unchanged.
- `0001` is JMP: `pc <= ir[9:0]`.
- `0010` is JZ: jump to `ir[9:0]` if `zf=1`, else `pc+1`.
- `0011` is JNZ: jump to `ir[9:0]` if `zf=0`, else `pc+1`.
- `0101` is HALT.
- Every other opcode (including `0100`) is a NOP: `pc+1`, no write.
- When `ir[15]=0`, `op_alu=000`. `ra1`, `ra2`, `wa` and `inm` follow the bit fields regardless of opcode; they are only meaningful when `we3=1`.
- State machine:
  - FETCH: `pc` stable on the bus. Next state LOAD.
  - LOAD: `ir <= instr`. Next state EXEC.
  - EXEC: `we3` asserted for writing ops. `zf` captured for ALU ops. `pc` updated (jump target or `pc+1`). Next state FETCH, or HALT for a HALT op.
  - HALT: `halted=1`, `we3=0`, `pc` frozen. Left only by reset.
- PC arithmetic is modulo 1024: `pc+1` at 1023 wraps to 0. Jump targets are 10 bits with no wrap logic.
- `we3` is 0 in every state other than EXEC.
- Reset values: state FETCH, `pc=0`, `ir=16'h4000` (NOP), `zf=0`, `we3=0`, `halted=0`, `op_alu=000`, `s_inm=0`.
- Reset wins over every other event in the same cycle, including mid-EXEC: no write occurs on that edge and `pc` returns to 0.

## Timing
- Each instruction takes exactly 3 cycles (FETCH, LOAD, EXEC). There are no stalls.
- `instr` is sampled at the end of LOAD, i.e. one cycle after `pc` was presented in FETCH.
- `zf` is sampled from `zero` at the end of EXEC of an ALU op. A JZ/JNZ immediately following sees the updated `zf`.
- All outputs are registered or decoded from registered state only. There is no combinational path from `zero` or `instr` to any output.
- The new `pc` is visible in the FETCH cycle that follows EXEC.

## Test plan
- Reset:
  - Hold `reset=0` for 2 cycles, then release.
  - Require `pc=0`, `we3=0`, `halted=0`, `op_alu=000`.
  - Require the first FETCH in the cycle after release.
- LOADI:
  - `instr=16'h0A53`.
  - Require `we3=1` for exactly one cycle, 2 cycles after FETCH, with `inm=8'hA5`, `wa=3`, `s_inm=1`.
  - Require `pc` 0→1 over 3 cycles.
- SUB then JZ taken:
  - `16'hB125` (`op_alu=011`, `ra1=1`, `ra2=2`, `wa=5`), with the bench driving `zero=1` in EXEC; next `16'h2155`.
  - Require `zf=1` and next `pc=0x155`.
  - Repeat with `zero=0`: require JZ to fall through to `pc+1`, and JNZ `16'h3155` to jump to `0x155`.
- PC wrap:
  - JMP `16'h13FF`, then a NOP at 1023.
  - Require `pc` to go 1023→0.
- HALT:
  - `16'h5000`.
  - Require `halted=1`, `pc` frozen and `we3=0` for 20 cycles.
  - Reset then restarts at `pc=0`.
- Reset mid-EXEC:
  - Assert `reset=0` during EXEC of an ALU op.
  - Require no `we3` pulse, `zf=0` and `pc=0` on the next cycle.
